reset_sequencer: RTL

- Parametrised successor to the board-level cold-reset counter and clock divider.
- Holds NUM_CH downstream reset domains (PCIe, ETH, user logic) in reset until the reference clock is locked and a cold-wait has expired.
- Releases the domains one at a time in index order, re-sequences on loss of lock or on a soft-reset request, and provides a divided clock-enable.

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/sync_bit.sv | 23 ++
 rtl/reset_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    COLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int                     RST_COUNT_W   = 8;
  localparam logic [RST_COUNT_W-1:0] RST_COUNT_MAX = 8'd255;

  function automatic logic [RST_COUNT_W-1:0] sat_inc(input logic [RST_COUNT_W-1:0] v);
    return (v == RST_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Holds NUM_CH reset domains until lock + cold wait, then releases them one
// by one; re-sequences on lock loss or soft request. Also a free-running CE.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int COLD_CYCLES = 16384,
  parameter int STAGE_GAP   = 256,
  parameter int SYNC_STAGES = 2,
  parameter int DIV         = 2
) (
  input  logic                   clk200,
  input  logic                   sys_rst_n,
  input  logic                   pll_locked,
  input  logic                   soft_rst_req,
  output logic [NUM_CH-1:0]      rst_out,
  output logic                   all_ready,
  output logic [1:0]             state_o,
  output logic [RST_COUNT_W-1:0] rst_count,
  output logic                   ce_div
);

  localparam int CNT_MAX = (COLD_CYCLES > STAGE_GAP) ? COLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_CH + 1);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] COLD_LAST = CNT_W'(COLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

  logic locked_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk200),
    .rst_n (sys_rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [NUM_CH-1:0]      rst_q,   rst_d;
  logic                   ready_q, ready_d;
  logic [RST_COUNT_W-1:0] rcnt_q,  rcnt_d;
  logic [DIV_W-1:0]       div_q,   div_d;
  logic                   ce_q,    ce_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    rcnt_d  = rcnt_q;

    unique case (state_q)
      COLD: begin
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == COLD_LAST) begin
          state_d = STAGE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STAGE: begin
        if (!locked_s) begin
          state_d = COLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          rcnt_d  = sat_inc(rcnt_q);
        end else if (cnt_q == GAP_LAST) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IDX_W'(k)) rst_d[k] = 1'b0;
          end
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        // Lock loss takes priority over a coincident soft request.
        if (!locked_s) begin
          state_d = COLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          rcnt_d  = sat_inc(rcnt_q);
        end else if (soft_rst_req) begin
          state_d = STAGE;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          rcnt_d  = sat_inc(rcnt_q);
        end
      end

      default: begin
        state_d = COLD;
        cnt_d   = '0;
        idx_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase
  end

  // With DIV=1 the counter never leaves 0, so the wrap (and ce) fires every cycle.
  always_comb begin
    ce_d  = (div_q == DIV_LAST);
    div_d = ce_d ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk200 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= COLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      rcnt_q  <= '0;
      div_q   <= '0;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      rcnt_q  <= rcnt_d;
      div_q   <= div_d;
      ce_q    <= ce_d;
    end
  end

  assign rst_out   = rst_q;
  assign all_ready = ready_q;
  assign state_o   = state_q;
  assign rst_count = rcnt_q;
  assign ce_div    = ce_q;

endmodule
